alu_pipe_hs: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output. Successor to the combinational datapath ALU.

---
 rtl/alu_pipe_hs.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe_hs.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs
//   Registered ALU with valid/ready handshakes on both sides. It sits between
//   the operand stage and writeback and holds each result until the consumer
//   takes it.
//
//   Optional feature macro: ALU_MUL_EN
//     defined   - opcode 4'b1000 runs a WIDTH-cycle shift-add multiply
//                 (state MUL, busy asserted).
//     undefined - no multiplier is built, busy is tied low and opcode
//                 4'b1000 behaves as an illegal opcode.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; transfer when both are high
//   op_code               0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt,
//                         1100 nor, 0100 sll, 0101 srl, 1000 mul
//   a, b, shamt           operands and shift amount
//   out_valid / out_ready output handshake; transfer when both are high
//   result                registered result
//   zero_flag             result == 0
//   overflow              signed overflow for add/sub, 0 otherwise
//   busy                  multiply in progress
module alu_pipe_hs #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD
`ifdef ALU_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic             accept;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_mul;
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign overflow  = ovf_q;

`ifdef ALU_MUL_EN
  assign busy     = (state_q == S_MUL);
  assign is_mul   = (op_code == 4'b1000);
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`else
  assign busy = 1'b0;
`endif

  assign sum  = a + b;
  assign diff = a - b;

  // Single-cycle datapath; unlisted opcodes yield 0 with no overflow.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_code)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: alu_res = ~(a | b);
      4'b0100: alu_res = a << shamt;
      4'b0101: alu_res = a >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_HOLD: if (out_ready) state_d = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL: begin
        // Multiplicand shifts left, multiplier right; one partial product per cycle.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = S_HOLD;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          ovf_d    = 1'b0;
          cnt_d    = '0;
        end
      end
`endif
      default: ;
    endcase

    // An accept in HOLD overrides the return to IDLE, giving back-to-back throughput.
    if (accept) begin
`ifdef ALU_MUL_EN
      if (is_mul) begin
        state_d  = S_MUL;
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = S_HOLD;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        ovf_d    = alu_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb_alu_pipe_hs
//   Directed bench for alu_pipe_hs (WIDTH=32). Expected results come from a
//   behavioural model, are queued at accept and checked when the DUT hands
//   the result over. Expectations for opcode 1000 follow ALU_MUL_EN.
module tb_alu_pipe_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_code = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero_flag;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  alu_pipe_hs #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_flag (zero_flag),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input logic [4:0] s);
    exp_t e;
    logic [63:0] p;
    e.r  = 32'h0;
    e.ov = 1'b0;
    case (op)
      4'h0: e.r = x & y;
      4'h1: e.r = x | y;
      4'h2: begin
        e.r  = x + y;
        e.ov = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      4'h6: begin
        e.r  = x - y;
        e.ov = (x[31] != y[31]) && (e.r[31] != x[31]);
      end
      4'h7: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'hC: e.r = ~(x | y);
      4'h4: e.r = x << s;
      4'h5: e.r = x >> s;
`ifdef ALU_MUL_EN
      4'h8: begin
        p   = 64'(x) * 64'(y);
        e.r = p[31:0];
      end
`endif
      default: e.r = 32'h0;
    endcase
    e.z = (e.r == 32'h0);
    return e;
  endfunction

  // Consumer side: every handshaked result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", {63'h0, out_valid}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_zero", zero_flag, e.z);
        chk("sb_overflow", overflow, e.ov);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and returns 1 ns after the edge on which it was accepted.
  task automatic send(input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] s);
    int unsigned n = 0;
    op_code  = op;
    a        = x;
    b        = y;
    shamt    = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else sb.push_back(model(op, x, y, s));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned c0;
    logic [3:0] ops [10];
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h4, 4'h5, 4'h3, 4'hF};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    step();
    chk("idle_out_valid", out_valid, 0);

    // 1: add with signed overflow
    out_ready = 1'b1;
    send(4'h2, 32'h7FFFFFFF, 32'h1, 5'd0);
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_result", result, 32'h80000000);
    chk("add_overflow", overflow, 1);
    chk("add_zero", zero_flag, 0);

    // 2: sub to zero, then nor
    send(4'h6, 32'd5, 32'd5, 5'd0);
    chk("sub_result", result, 0);
    chk("sub_zero", zero_flag, 1);
    chk("sub_overflow", overflow, 0);
    send(4'hC, 32'h0, 32'h0, 5'd0);
    in_valid = 1'b0;
    chk("nor_result", result, 32'hFFFFFFFF);
    chk("nor_zero", zero_flag, 0);
    step();

    // 3: back-to-back single-cycle ops
    c0 = cyc;
    send(4'h7, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("slt_result", result, 1);
    send(4'h4, 32'h1, 32'h0, 5'd31);
    chk("sll_out_valid", out_valid, 1);
    chk("sll_result", result, 32'h80000000);
    send(4'h5, 32'h80000000, 32'h0, 5'd31);
    in_valid = 1'b0;
    chk("srl_result", result, 1);
    chk("b2b_cycles", cyc - c0, 3);

    // Illegal opcode
    send(4'h3, 32'h1234, 32'h5678, 5'd3);
    in_valid = 1'b0;
    chk("illegal_result", result, 0);
    chk("illegal_zero", zero_flag, 1);
    step();

    // 4: multiply
    send(4'h8, 32'h0000FFFF, 32'h00010001, 5'd0);
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_out_valid", out_valid, 0);
      step();
    end
    chk("mul_done_valid", out_valid, 1);
    chk("mul_done_busy", busy, 0);
    chk("mul_result", result, 32'hFFFFFFFF);
    chk("mul_zero", zero_flag, 0);
`else
    chk("mul_off_valid", out_valid, 1);
    chk("mul_off_busy", busy, 0);
    chk("mul_off_result", result, 0);
    chk("mul_off_zero", zero_flag, 1);
`endif
    step();

    // 5: backpressure, then accept alongside the drain
    out_ready = 1'b0;
    send(4'h0, 32'h0F0F0F0F, 32'hFFFFFFFF, 5'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", result, 32'h0F0F0F0F);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    send(4'h1, 32'h1, 32'h2, 5'd0);
    in_valid = 1'b0;
    chk("bp_or_result", result, 3);
    chk("bp_or_valid", out_valid, 1);
    step();

    // 6: reset in the middle of a multiply
    send(4'h8, 32'h0000FFFF, 32'h00010001, 5'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    sb.delete();
    chk("rstmul_out_valid", out_valid, 0);
    chk("rstmul_busy", busy, 0);
    chk("rstmul_result", result, 0);
    chk("rstmul_in_ready", in_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("rstmul_no_stale", out_valid, 0);

    // Mixed single-cycle ops
    for (int i = 0; i < 20; i++) begin
      send(ops[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
